// File: rtl/valid_pipe_credit_adapter_pkg.sv
// Shared width helpers and default parameters for the valid-pipe credit adapter.
package valid_pipe_credit_adapter_pkg;

   localparam int unsigned DEF_WIDTH   = 32;
   localparam int unsigned DEF_LATENCY = 3;
   localparam int unsigned DEF_DEPTH   = 4;

   // Bits needed to index DEPTH entries (at least one bit).
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Bits needed to hold the values 0..n inclusive (at least one bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 0) ? $clog2(n + 1) : 1;
   endfunction

endpackage

// File: rtl/valid_pipe_credit_adapter_credit_fifo.sv
// Synchronous FIFO catching pipeline outputs; drops and flags a push that finds no room.
module valid_pipe_credit_adapter_credit_fifo
   import valid_pipe_credit_adapter_pkg::*;
#(
   parameter  int unsigned WIDTH = DEF_WIDTH,
   parameter  int unsigned DEPTH = DEF_DEPTH,
   localparam int unsigned PTR_W = ptr_w(DEPTH),
   localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             empty;
   logic             do_push;
   logic             do_pop;
   logic             drop;

   // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop frees the head slot this cycle, so a push while full still lands in order.
   assign do_push = push && (!full || do_pop);
   assign drop    = push && full && !do_pop;
   assign rd_data = mem[rd_ptr];

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/valid_pipe_credit_adapter.sv
// Wraps a fixed-latency, non-stallable, non-reset valid pipeline with ready/valid
// streams, using credits so the output FIFO can always absorb what the pipe emits.
module valid_pipe_credit_adapter
   import valid_pipe_credit_adapter_pkg::*;
#(
   parameter  int unsigned WIDTH   = DEF_WIDTH,
   parameter  int unsigned LATENCY = DEF_LATENCY,
   parameter  int unsigned DEPTH   = DEF_DEPTH,
   localparam int unsigned CRED_W  = cnt_w(DEPTH),
   localparam int unsigned FLUSH_W = cnt_w(LATENCY)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WIDTH-1:0]  s_data,
   output logic              pipe_in_valid,
   output logic [WIDTH-1:0]  pipe_in_data,
   input  logic              pipe_out_valid,
   input  logic [WIDTH-1:0]  pipe_out_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WIDTH-1:0]  m_data,
   output logic [CRED_W-1:0] credits,
   output logic              overflow_err
);

   logic [FLUSH_W-1:0] flush_cnt;
   logic               flushing;
   logic               issue;
   logic               push;
   logic               pop;
   logic [CRED_W-1:0]  credits_nxt;
   logic [CRED_W-1:0]  fifo_count;

   // The pipe holds garbage after reset, so its outputs are ignored for LATENCY cycles.
   assign flushing      = (flush_cnt != '0);
   assign s_ready       = !flushing && (credits != '0);
   assign issue         = s_valid && s_ready;
   assign pipe_in_valid = issue;
   assign pipe_in_data  = s_data;
   assign push          = pipe_out_valid && !flushing;
   assign m_valid       = (fifo_count != '0);
   assign pop           = m_valid && m_ready;

   // Post-reset flush countdown.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt <= FLUSH_W'(LATENCY);
      end else if (flushing) begin
         flush_cnt <= flush_cnt - FLUSH_W'(1);
      end
   end

   // Credit update: issue consumes, pop returns; a returned credit is usable next cycle.
   always_comb begin
      credits_nxt = credits;
      if (issue && !pop) begin
         credits_nxt = credits - CRED_W'(1);
      end else if (pop && !issue && (credits != CRED_W'(DEPTH))) begin
         // Saturate so a misbehaving pipe cannot wrap the counter past DEPTH.
         credits_nxt = credits + CRED_W'(1);
      end
   end

   // Credit register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits <= CRED_W'(DEPTH);
      end else begin
         credits <= credits_nxt;
      end
   end

   valid_pipe_credit_adapter_credit_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .wr_data  (pipe_out_data),
      .pop      (pop),
      .rd_data  (m_data),
      .count    (fifo_count),
      .overflow (overflow_err)
   );

endmodule

// File: tb/tb_valid_pipe_credit_adapter.sv
// Bench for valid_pipe_credit_adapter: model x+3 pipeline, scoreboard on the output
// stream, a per-cycle vector table for the backpressure sequence, and hand sequences.
module tb_valid_pipe_credit_adapter;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned LATENCY = 3;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned CRED_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              s_valid;
   logic              s_ready;
   logic [WIDTH-1:0]  s_data;
   logic              pipe_in_valid;
   logic [WIDTH-1:0]  pipe_in_data;
   logic              pipe_out_valid;
   logic [WIDTH-1:0]  pipe_out_data;
   logic              m_valid;
   logic              m_ready;
   logic [WIDTH-1:0]  m_data;
   logic [CRED_W-1:0] credits;
   logic              overflow_err;

   logic              rogue_v;
   logic [WIDTH-1:0]  rogue_d;

   int tests = 0;
   int fails = 0;
   logic [WIDTH-1:0] exp_q[$];

   always #5 clk = ~clk;

   valid_pipe_credit_adapter #(
      .WIDTH   (WIDTH),
      .LATENCY (LATENCY),
      .DEPTH   (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_data         (s_data),
      .pipe_in_valid  (pipe_in_valid),
      .pipe_in_data   (pipe_in_data),
      .pipe_out_valid (pipe_out_valid),
      .pipe_out_data  (pipe_out_data),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_data         (m_data),
      .credits        (credits),
      .overflow_err   (overflow_err)
   );

   // Model pipeline: x+3, LATENCY stages, no reset, preloaded with stale valids.
   logic [LATENCY-1:0] pv;
   logic [WIDTH-1:0]   pd [LATENCY];
   initial begin
      pv = '1;
      for (int i = 0; i < int'(LATENCY); i++) pd[i] = 32'hDEAD_BEEF;
   end
   always @(posedge clk) begin
      pv    <= {pv[LATENCY-2:0], pipe_in_valid};
      pd[0] <= pipe_in_data + 32'd3;
      for (int i = 1; i < int'(LATENCY); i++) pd[i] <= pd[i-1];
   end
   assign pipe_out_valid = pv[LATENCY-1] | rogue_v;
   assign pipe_out_data  = rogue_v ? rogue_d : pd[LATENCY-1];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Scoreboard: push on upstream transfer, pop/compare on downstream transfer.
   always @(negedge clk) begin
      if (s_valid && s_ready) exp_q.push_back(s_data + 32'd3);
      if (pipe_in_valid) chk("credit_underflow", 32'(credits == '0), 32'd0);
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0) chk("sb_unexpected_output", m_data, 32'hFFFF_FFFF);
         else                   chk("sb_data", m_data, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      s_valid = 1'b0;
      m_ready = 1'b1;
      while (n < 60) begin
         @(negedge clk);
         if (credits == CRED_W'(DEPTH) && !m_valid) break;
         next_cycle();
         n++;
      end
      chk("drain_idle", 32'(credits == CRED_W'(DEPTH) && !m_valid), 32'd1);
      chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
      next_cycle();
   endtask

   typedef struct {
      logic              s_valid;
      logic [31:0]       s_data;
      logic              m_ready;
      logic              exp_s_ready;
      logic [CRED_W-1:0] exp_credits;
      logic              exp_m_valid;
   } vec_t;

   function automatic vec_t mk(input logic sv, input logic [31:0] sd, input logic mr,
                               input logic er, input int ec, input logic emv);
      vec_t v;
      v.s_valid     = sv;
      v.s_data      = sd;
      v.m_ready     = mr;
      v.exp_s_ready = er;
      v.exp_credits = CRED_W'(ec);
      v.exp_m_valid = emv;
      return v;
   endfunction

   initial begin
      vec_t tbl[16];
      int idx, cyc, first_acc, last_acc, first_mv, acc;

      // Backpressure: 6 items, m_ready low except one pulse; credit loop is 5 cycles.
      tbl[0]  = mk(1, 32'h100, 0, 1, 4, 0);
      tbl[1]  = mk(1, 32'h101, 0, 1, 3, 0);
      tbl[2]  = mk(1, 32'h102, 0, 1, 2, 0);
      tbl[3]  = mk(1, 32'h103, 0, 1, 1, 0);
      tbl[4]  = mk(1, 32'h104, 0, 0, 0, 1);
      tbl[5]  = mk(1, 32'h104, 0, 0, 0, 1);
      tbl[6]  = mk(1, 32'h104, 0, 0, 0, 1);
      tbl[7]  = mk(1, 32'h104, 1, 0, 0, 1);
      tbl[8]  = mk(1, 32'h104, 0, 1, 1, 1);
      tbl[9]  = mk(1, 32'h105, 1, 0, 0, 1);
      tbl[10] = mk(1, 32'h105, 1, 1, 1, 1);
      tbl[11] = mk(0, 32'h0,   1, 1, 1, 1);
      tbl[12] = mk(0, 32'h0,   1, 1, 2, 1);
      tbl[13] = mk(0, 32'h0,   1, 1, 3, 0);
      tbl[14] = mk(0, 32'h0,   1, 1, 3, 1);
      tbl[15] = mk(0, 32'h0,   0, 1, 4, 0);

      s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      rogue_v = 1'b0; rogue_d = '0; rst_n = 1'b0;

      // Reset state, with upstream trying to send.
      repeat (4) @(posedge clk);
      #1 s_valid = 1'b1; s_data = 32'h55;
      @(negedge clk);
      chk("rst_s_ready",       32'(s_ready),       32'd0);
      chk("rst_m_valid",       32'(m_valid),       32'd0);
      chk("rst_pipe_in_valid", 32'(pipe_in_valid), 32'd0);
      chk("rst_credits",       32'(credits),       32'(DEPTH));
      chk("rst_overflow",      32'(overflow_err),  32'd0);

      // Release with stale valids emerging from the pipe for two cycles.
      next_cycle();
      s_valid = 1'b0;
      rst_n   = 1'b1;
      rogue_d = 32'hDEAD_BEEF;
      for (int k = 0; k < 6; k++) begin
         rogue_v = (k < 2);
         @(negedge clk);
         chk($sformatf("flush[%0d].s_ready", k), 32'(s_ready), 32'(k >= int'(LATENCY)));
         chk($sformatf("flush[%0d].m_valid", k), 32'(m_valid), 32'd0);
         chk($sformatf("flush[%0d].overflow", k), 32'(overflow_err), 32'd0);
         next_cycle();
      end
      rogue_v = 1'b0;
      chk("flush_credits", 32'(credits), 32'(DEPTH));

      // Streaming 0..99; each credit is tied up 5 cycles so 4 issues per 5 cycles.
      m_ready = 1'b1; idx = 0; cyc = 0; first_acc = -1; last_acc = -1; first_mv = -1;
      while (idx < 100 && cyc < 400) begin
         s_valid = 1'b1;
         s_data  = 32'(idx);
         @(negedge clk);
         if (s_ready) begin
            if (idx == 0) first_acc = cyc;
            last_acc = cyc;
            idx++;
         end
         if (m_valid && first_mv < 0) first_mv = cyc;
         next_cycle();
         cyc++;
      end
      s_valid = 1'b0;
      chk("stream_accepted",     32'(idx), 32'd100);
      chk("stream_first_latency", 32'(first_mv - first_acc), 32'(LATENCY + 1));
      chk("stream_span",         32'(last_acc - first_acc), 32'd123);
      drain();

      // Table-driven backpressure sequence.
      for (int i = 0; i < 16; i++) begin
         s_valid = tbl[i].s_valid;
         s_data  = tbl[i].s_data;
         m_ready = tbl[i].m_ready;
         @(negedge clk);
         chk($sformatf("bp[%0d].s_ready", i), 32'(s_ready), 32'(tbl[i].exp_s_ready));
         chk($sformatf("bp[%0d].credits", i), 32'(credits), 32'(tbl[i].exp_credits));
         chk($sformatf("bp[%0d].m_valid", i), 32'(m_valid), 32'(tbl[i].exp_m_valid));
         next_cycle();
      end
      drain();

      // Simultaneous issue and pop from a full FIFO.
      m_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         s_valid = 1'b1; s_data = 32'(200 + k);
         next_cycle();
      end
      s_valid = 1'b0;
      repeat (4) next_cycle();
      @(negedge clk);
      chk("sim_full_m_valid", 32'(m_valid), 32'd1);
      chk("sim_full_credits", 32'(credits), 32'd0);
      next_cycle();
      m_ready = 1'b1; acc = 0;
      for (int k = 0; k < 4; k++) begin
         s_valid = 1'b1; s_data = 32'(300 + acc);
         @(negedge clk);
         if (k > 0) begin
            chk($sformatf("sim[%0d].credits", k), 32'(credits), 32'd1);
            chk($sformatf("sim[%0d].issue_pop", k), 32'(s_ready && m_valid), 32'd1);
         end
         if (s_ready) acc++;
         next_cycle();
      end
      drain();

      // Overflow: rogue output while full and stalled.
      m_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         s_valid = 1'b1; s_data = 32'(400 + k);
         next_cycle();
      end
      s_valid = 1'b0;
      repeat (4) next_cycle();
      @(negedge clk);
      chk("ovf_pre_m_valid",  32'(m_valid), 32'd1);
      chk("ovf_pre_flag",     32'(overflow_err), 32'd0);
      next_cycle();
      rogue_v = 1'b1; rogue_d = 32'hBAD0_BAD0;
      next_cycle();
      rogue_v = 1'b0;
      @(negedge clk);
      chk("ovf_flag",    32'(overflow_err), 32'd1);
      chk("ovf_head",    m_data, 32'd403);
      chk("ovf_credits", 32'(credits), 32'd0);
      next_cycle();
      drain();
      chk("ovf_sticky", 32'(overflow_err), 32'd1);

      // Mid-run reset with items both queued and in flight.
      m_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         s_valid = 1'b1; s_data = 32'(500 + k);
         next_cycle();
      end
      s_valid = 1'b0;
      next_cycle();
      @(negedge clk);
      chk("mrst_pre_m_valid", 32'(m_valid), 32'd1);
      next_cycle();
      #1 rst_n = 1'b0;
      #1;
      chk("mrst_async_m_valid", 32'(m_valid), 32'd0);
      chk("mrst_async_credits", 32'(credits), 32'(DEPTH));
      chk("mrst_async_s_ready", 32'(s_ready), 32'd0);
      chk("mrst_async_overflow", 32'(overflow_err), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("mrst[%0d].s_ready", k), 32'(s_ready), 32'(k >= int'(LATENCY)));
         chk($sformatf("mrst[%0d].m_valid", k), 32'(m_valid), 32'd0);
         next_cycle();
      end
      chk("mrst_credits", 32'(credits), 32'(DEPTH));
      m_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         s_valid = 1'b1; s_data = 32'(600 + k);
         next_cycle();
      end
      drain();

      chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
